// File: rtl/xentry_pkg.sv
// Shared types and helpers for the L1 data-cache datapath.
//   memory_operation_size_e : access size of a pipeline load/store
//   clog2_min1()            : ceil(log2(n)), never smaller than 1
//   way_idx_w()             : width of a way index for a given way count
package xentry_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } memory_operation_size_e;

  function automatic int clog2_min1(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << w) < n) w++;
    end
    return (w < 1) ? 1 : w;
  endfunction

  // A 1-way cache still carries a 1-bit (always zero) way index.
  function automatic int way_idx_w(input int num_ways);
    return clog2_min1(num_ways);
  endfunction

endpackage

// File: rtl/dcache_assoc_datapath_plru_tree.sv
// Tree pseudo-LRU decode/update for one set.
//   tree_bits  : NUM_WAYS-1 node bits, heap order (node n has children
//                2n+1 and 2n+2); a node value of 0 points at the left subtree
//   access_way : way being made most-recently-used
//   victim_way : way the tree currently points at
//   next_bits  : tree bits after touching access_way (path points away)
// For NUM_WAYS == 1 the tree is empty: victim is 0 and bits pass through.
module plru_tree
  import xentry_pkg::*;
#(
  parameter int NUM_WAYS = 4,
  localparam int WAY_W  = way_idx_w(NUM_WAYS),
  localparam int TREE_W = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1
) (
  input  logic [TREE_W-1:0] tree_bits,
  input  logic [WAY_W-1:0]  access_way,
  output logic [WAY_W-1:0]  victim_way,
  output logic [TREE_W-1:0] next_bits
);

  localparam int LEVELS = (NUM_WAYS > 1) ? WAY_W : 0;

  // Walk from the root following each node's bit; the bits taken, MSB
  // first, form the victim way index.
  always_comb begin : victim_walk
    int node;
    victim_way = '0;
    node = 0;
    for (int lvl = 0; lvl < LEVELS; lvl++) begin
      victim_way[LEVELS-1-lvl] = tree_bits[node];
      node = 2 * node + 1 + int'(tree_bits[node]);
    end
  end

  // Walk the path to access_way and flip every node on it to point away.
  always_comb begin : touch_walk
    int   node;
    logic dir;
    next_bits = tree_bits;
    node = 0;
    for (int lvl = 0; lvl < LEVELS; lvl++) begin
      dir = access_way[LEVELS-1-lvl];
      next_bits[node] = ~dir;
      node = 2 * node + 1 + int'(dir);
    end
  end

endmodule

// File: rtl/dcache_assoc_datapath.sv
// N-way set-associative L1 data-cache datapath.
// Holds tag/valid/dirty/data/PLRU state, does parallel hit detection,
// byte/half/word access, victim selection and word-serial L2 fill/flush.
// Ports:
//   pipe_req_*            request address fields, size and store data
//   pipe_fetched_word     zero-extended read data from the active way
//   l2_req_address        {l2_block_address, counter, 0s}
//   l2_fetched_word       fill data (write source in load_mode)
//   l2_word_to_store      active-way word at counter (writeback data)
//   flush_mode/load_mode  word-serial access: WORD size, word=counter
//   perform_write, set/clear_selected_dirty_bit, clear_selected_valid_bit
//                         act on the active way
//   finish_new_line_install  validate victim_q, write request tag into it
//   latch_victim          capture victim way and L2 block address
//   touch_lru             make hit way most-recently-used
//   reset_counter/decrement_counter, counter_done
//   valid_block_match     some valid way matches the tag
//   valid_dirty_bit       current victim way is valid and dirty
// Active way: hit_way for normal pipeline accesses, victim_q while either
// mode is set or between latch_victim and finish_new_line_install.
module dcache_assoc_datapath
  import xentry_pkg::*;
#(
  parameter int LINE_SIZE = 32,
  parameter int OFS_SIZE  = 5,
  parameter int SET_SIZE  = 3,
  parameter int TAG_SIZE  = 24,
  parameter int NUM_SETS  = 8,
  parameter int NUM_WAYS  = 4,
  parameter int XLEN      = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [OFS_SIZE-1:0]    pipe_req_ofs,
  input  logic [SET_SIZE-1:0]    pipe_req_set,
  input  logic [TAG_SIZE-1:0]    pipe_req_tag,
  input  memory_operation_size_e pipe_req_size,
  input  logic [XLEN-1:0]        pipe_word_to_store,
  output logic [XLEN-1:0]        pipe_fetched_word,
  output logic [XLEN-1:0]        l2_req_address,
  input  logic [XLEN-1:0]        l2_fetched_word,
  output logic [XLEN-1:0]        l2_word_to_store,
  input  logic                   flush_mode,
  input  logic                   load_mode,
  input  logic                   perform_write,
  input  logic                   set_selected_dirty_bit,
  input  logic                   clear_selected_dirty_bit,
  input  logic                   clear_selected_valid_bit,
  input  logic                   finish_new_line_install,
  input  logic                   latch_victim,
  input  logic                   touch_lru,
  input  logic                   reset_counter,
  input  logic                   decrement_counter,
  output logic                   counter_done,
  output logic                   valid_block_match,
  output logic                   valid_dirty_bit
);

  localparam int BYTES_PER_WORD = XLEN / 8;
  localparam int WORDS  = LINE_SIZE / BYTES_PER_WORD;
  localparam int CNT_W  = clog2_min1(WORDS);
  localparam int BYTE_W = clog2_min1(BYTES_PER_WORD);
  localparam int WAY_W  = way_idx_w(NUM_WAYS);
  localparam int TREE_W = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1;
  localparam int BLK_W  = TAG_SIZE + SET_SIZE;

  // Arrays
  logic [TAG_SIZE-1:0] tag_q   [NUM_SETS][NUM_WAYS];
  logic [TAG_SIZE-1:0] tag_d   [NUM_SETS][NUM_WAYS];
  logic [XLEN-1:0]     data_q  [NUM_SETS][NUM_WAYS][WORDS];
  logic [XLEN-1:0]     data_d  [NUM_SETS][NUM_WAYS][WORDS];
  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0] valid_d [NUM_SETS];
  logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
  logic [NUM_WAYS-1:0] dirty_d [NUM_SETS];
  logic [TREE_W-1:0]   plru_q  [NUM_SETS];
  logic [TREE_W-1:0]   plru_d  [NUM_SETS];

  // Control registers
  logic [WAY_W-1:0] victim_q, victim_d;
  logic             victim_latched_q, victim_latched_d;
  logic [CNT_W-1:0] counter_q, counter_d;
  logic [BLK_W-1:0] l2_block_address_q, l2_block_address_d;

  // Combinational
  logic [SET_SIZE-1:0]    set_idx;
  logic [NUM_WAYS-1:0]    hit_vec;
  logic [WAY_W-1:0]       hit_way;
  logic [WAY_W-1:0]       victim;
  logic [WAY_W-1:0]       plru_victim;
  logic [WAY_W-1:0]       plru_access;
  logic [TREE_W-1:0]      plru_next;
  logic [WAY_W-1:0]       active_way;
  logic                   serial_mode;
  logic [CNT_W-1:0]       eff_word;
  logic [BYTE_W-1:0]      eff_byte;
  memory_operation_size_e eff_size;
  logic [XLEN-1:0]        write_data;
  logic [XLEN-1:0]        write_bus;
  logic [BYTES_PER_WORD-1:0] byte_en;
  logic                   write_en;
  logic [XLEN-1:0]        rd_word;
  logic [XLEN-1:0]        rd_shifted;

  assign set_idx = pipe_req_set;

  // Hit detection
  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      hit_vec[w] = valid_q[set_idx][w] && (tag_q[set_idx][w] == pipe_req_tag);
    end
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = WAY_W'(w);
    end
  end

  assign valid_block_match = |hit_vec;

  // Victim: lowest-index invalid way, else the PLRU choice
  assign plru_access = finish_new_line_install ? victim_q : hit_way;

  plru_tree #(.NUM_WAYS(NUM_WAYS)) u_plru (
    .tree_bits  (plru_q[set_idx]),
    .access_way (plru_access),
    .victim_way (plru_victim),
    .next_bits  (plru_next)
  );

  always_comb begin
    victim = plru_victim;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_q[set_idx][w]) victim = WAY_W'(w);
    end
  end

  assign valid_dirty_bit = valid_q[set_idx][victim] & dirty_q[set_idx][victim];

  // Access steering
  assign serial_mode = flush_mode | load_mode;
  assign active_way  = (serial_mode || victim_latched_q) ? victim_q : hit_way;
  assign eff_word    = serial_mode ? counter_q : pipe_req_ofs[BYTE_W +: CNT_W];
  assign eff_byte    = serial_mode ? '0 : pipe_req_ofs[BYTE_W-1:0];
  assign eff_size    = serial_mode ? WORD : pipe_req_size;
  assign write_data  = load_mode ? l2_fetched_word : pipe_word_to_store;
  assign write_en    = perform_write && (valid_block_match || victim_latched_q);

  always_comb begin
    case (eff_size)
      BYTE: begin
        write_bus = {BYTES_PER_WORD{write_data[7:0]}};
        byte_en   = {{(BYTES_PER_WORD-1){1'b0}}, 1'b1} << eff_byte;
      end
      HALF: begin
        write_bus = {(XLEN/16){write_data[15:0]}};
        byte_en   = {{(BYTES_PER_WORD-2){1'b0}}, 2'b11} << {eff_byte[BYTE_W-1:1], 1'b0};
      end
      default: begin
        write_bus = write_data;
        byte_en   = '1;
      end
    endcase
  end

  assign rd_word          = data_q[set_idx][active_way][eff_word];
  assign l2_word_to_store = rd_word;

  always_comb begin
    case (eff_size)
      BYTE: begin
        rd_shifted        = rd_word >> {eff_byte, 3'b000};
        pipe_fetched_word = {{(XLEN-8){1'b0}}, rd_shifted[7:0]};
      end
      HALF: begin
        rd_shifted        = rd_word >> {eff_byte[BYTE_W-1:1], 1'b0, 3'b000};
        pipe_fetched_word = {{(XLEN-16){1'b0}}, rd_shifted[15:0]};
      end
      default: begin
        rd_shifted        = rd_word;
        pipe_fetched_word = rd_word;
      end
    endcase
  end

  assign l2_req_address = {l2_block_address_q, counter_q, {BYTE_W{1'b0}}};
  assign counter_done   = (counter_q == '0);

  // Next-state: arrays
  always_comb begin
    data_d = data_q;
    if (write_en) begin
      for (int b = 0; b < BYTES_PER_WORD; b++) begin
        if (byte_en[b]) data_d[set_idx][active_way][eff_word][b*8 +: 8] = write_bus[b*8 +: 8];
      end
    end
  end

  // Ordering inside this block encodes the priorities: clear_valid is
  // applied after install, clear_dirty after set_dirty.
  always_comb begin
    tag_d   = tag_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    plru_d  = plru_q;
    if (finish_new_line_install) begin
      valid_d[set_idx][victim_q] = 1'b1;
      tag_d[set_idx][victim_q]   = pipe_req_tag;
    end
    if (clear_selected_valid_bit) valid_d[set_idx][active_way] = 1'b0;
    if (set_selected_dirty_bit)   dirty_d[set_idx][active_way] = 1'b1;
    if (clear_selected_dirty_bit) dirty_d[set_idx][active_way] = 1'b0;
    // plru_access already prefers victim_q when install and touch coincide.
    if (finish_new_line_install || touch_lru) plru_d[set_idx] = plru_next;
  end

  // Next-state: control registers
  always_comb begin
    victim_d           = victim_q;
    victim_latched_d   = victim_latched_q;
    l2_block_address_d = l2_block_address_q;
    counter_d          = counter_q;
    if (latch_victim) begin
      victim_d           = victim;
      victim_latched_d   = 1'b1;
      l2_block_address_d = {valid_dirty_bit ? tag_q[set_idx][victim] : pipe_req_tag, set_idx};
    end else if (finish_new_line_install) begin
      victim_latched_d = 1'b0;
    end
    if (reset_counter)          counter_d = '1;
    else if (decrement_counter) counter_d = counter_q - 1'b1;
  end

  // Tags and data need no reset: valid bits gate every use of them.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q            <= '{default: '0};
      dirty_q            <= '{default: '0};
      plru_q             <= '{default: '0};
      victim_q           <= '0;
      victim_latched_q   <= 1'b0;
      counter_q          <= '1;
      l2_block_address_q <= '0;
    end else begin
      valid_q            <= valid_d;
      dirty_q            <= dirty_d;
      plru_q             <= plru_d;
      victim_q           <= victim_d;
      victim_latched_q   <= victim_latched_d;
      counter_q          <= counter_d;
      l2_block_address_q <= l2_block_address_d;
    end
  end

  // Controller contract
  a_single_hit : assert property (@(posedge clk) disable iff (reset) $onehot0(hit_vec));
  a_write_target : assert property (@(posedge clk) disable iff (reset)
    perform_write |-> (valid_block_match || victim_latched_q));

endmodule
